control_fsm: RTL and testbench

- Multi-cycle control sequencer directly downstream of the 16-bit datapath's `opcode` output.
- Decodes opcode[3:0] into the datapath strobes: RegDst, Branch, MemRead, MemWrite, RegWrite, MemToReg, ALUSrc, Shift, ALUOp.
- Adds a PCWrite enable so the datapath's PC update can be gated.
- Loads and stores take two cycles (address setup, then access). HALT freezes the machine until reset. A retired-instruction counter is kept for debug and verification.

---
 rtl/cpu_pkg.sv | 40 ++++
 rtl/main_decoder.sv | 68 ++++++
 rtl/control_fsm.sv | 107 ++++++++++
 tb/tb_control_fsm.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared opcode, ALUOp and state definitions for the control sequencer.
package cpu_pkg;

    localparam logic [3:0] OP_RTYPE = 4'b0000;
    localparam logic [3:0] OP_SHIFT = 4'b0001;
    localparam logic [3:0] OP_ADDI  = 4'b0010;
    localparam logic [3:0] OP_ANDI  = 4'b0011;
    localparam logic [3:0] OP_ORI   = 4'b0100;
    localparam logic [3:0] OP_LW    = 4'b0101;
    localparam logic [3:0] OP_SW    = 4'b0110;
    localparam logic [3:0] OP_BEQ   = 4'b0111;
    localparam logic [3:0] OP_HALT  = 4'b1111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_IMM   = 2'b11;

    // 2'b11 is unreachable and recovers to ST_EXEC.
    typedef enum logic [1:0] {
        ST_EXEC = 2'b00,
        ST_MEM  = 2'b01,
        ST_HALT = 2'b10
    } state_e;

    typedef struct packed {
        logic       reg_dst;
        logic       branch;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       mem_to_reg;
        logic       alu_src;
        logic       shift;
        logic [1:0] alu_op;
        logic       pc_write;
        logic       illegal;
    } ctrl_t;

endpackage

// File: rtl/main_decoder.sv
// Combinational opcode-to-strobe decode for the EXEC cycle.
module main_decoder
    import cpu_pkg::*;
#(
    parameter logic [3:0] HALT_OP = 4'b1111
) (
    input  logic [3:0]                opcode_i,
    output logic [$bits(ctrl_t)-1:0]  ctrl_o,
    output logic                      mem_op_o,
    output logic                      halt_o
);

    ctrl_t ctrl;

    always_comb begin
        ctrl     = '0;
        mem_op_o = 1'b0;
        halt_o   = 1'b0;
        if (opcode_i == HALT_OP) begin
            halt_o = 1'b1;
        end else begin
            case (opcode_i)
                OP_RTYPE: begin
                    ctrl.reg_dst   = 1'b1;
                    ctrl.reg_write = 1'b1;
                    ctrl.alu_op    = ALUOP_RTYPE;
                    ctrl.pc_write  = 1'b1;
                end
                OP_SHIFT: begin
                    ctrl.reg_dst   = 1'b1;
                    ctrl.reg_write = 1'b1;
                    ctrl.shift     = 1'b1;
                    ctrl.pc_write  = 1'b1;
                end
                OP_ADDI: begin
                    ctrl.alu_src   = 1'b1;
                    ctrl.reg_write = 1'b1;
                    ctrl.alu_op    = ALUOP_ADD;
                    ctrl.pc_write  = 1'b1;
                end
                OP_ANDI, OP_ORI: begin
                    ctrl.alu_src   = 1'b1;
                    ctrl.reg_write = 1'b1;
                    ctrl.alu_op    = ALUOP_IMM;
                    ctrl.pc_write  = 1'b1;
                end
                // Address setup only; the access happens in the MEM cycle.
                OP_LW, OP_SW: begin
                    ctrl.alu_src = 1'b1;
                    ctrl.alu_op  = ALUOP_ADD;
                    mem_op_o     = 1'b1;
                end
                OP_BEQ: begin
                    ctrl.branch   = 1'b1;
                    ctrl.alu_op   = ALUOP_SUB;
                    ctrl.pc_write = 1'b1;
                end
                default: begin
                    ctrl.illegal  = 1'b1;
                    ctrl.pc_write = 1'b1;
                end
            endcase
        end
    end

    assign ctrl_o = ctrl;

endmodule

// File: rtl/control_fsm.sv
// Multi-cycle control sequencer: EXEC/MEM/HALT state machine plus retired-instruction counter.
module control_fsm
    import cpu_pkg::*;
#(
    parameter int unsigned CNT_W   = 16,
    parameter logic [3:0]  HALT_OP = 4'b1111
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [3:0]       opcode,
    output logic             RegDst,
    output logic             Branch,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             RegWrite,
    output logic             MemToReg,
    output logic             ALUSrc,
    output logic             Shift,
    output logic [1:0]       ALUOp,
    output logic             PCWrite,
    output logic             Halted,
    output logic             IllegalOp,
    output logic [CNT_W-1:0] Retired
);

    state_e                   state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [$bits(ctrl_t)-1:0] dec_vec;
    logic                     dec_mem_op, dec_halt;
    ctrl_t                    dec_ctrl, ctrl;
    logic                     halted;

    main_decoder #(
        .HALT_OP (HALT_OP)
    ) u_main_decoder (
        .opcode_i (opcode),
        .ctrl_o   (dec_vec),
        .mem_op_o (dec_mem_op),
        .halt_o   (dec_halt)
    );

    assign dec_ctrl = dec_vec;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= ST_EXEC;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        ctrl    = '0;
        halted  = 1'b0;
        state_d = ST_EXEC;
        case (state_q)
            ST_EXEC: begin
                ctrl = dec_ctrl;
                if (dec_halt) begin
                    state_d = ST_HALT;
                end else if (dec_mem_op) begin
                    state_d = ST_MEM;
                end
            end
            // Decode from the live opcode: anything that is not LW is treated as SW.
            ST_MEM: begin
                ctrl.alu_src  = 1'b1;
                ctrl.alu_op   = ALUOP_ADD;
                ctrl.pc_write = 1'b1;
                if (opcode == OP_LW) begin
                    ctrl.mem_read   = 1'b1;
                    ctrl.mem_to_reg = 1'b1;
                    ctrl.reg_write  = 1'b1;
                end else begin
                    ctrl.mem_write = 1'b1;
                end
            end
            ST_HALT: begin
                halted  = 1'b1;
                state_d = ST_HALT;
            end
            default: ;
        endcase
        if (Reset) begin
            ctrl   = '0;
            halted = 1'b0;
        end
        cnt_d = cnt_q + CNT_W'(ctrl.pc_write);
    end

    assign RegDst    = ctrl.reg_dst;
    assign Branch    = ctrl.branch;
    assign MemRead   = ctrl.mem_read;
    assign MemWrite  = ctrl.mem_write;
    assign RegWrite  = ctrl.reg_write;
    assign MemToReg  = ctrl.mem_to_reg;
    assign ALUSrc    = ctrl.alu_src;
    assign Shift     = ctrl.shift;
    assign ALUOp     = ctrl.alu_op;
    assign PCWrite   = ctrl.pc_write;
    assign IllegalOp = ctrl.illegal;
    assign Halted    = halted;
    assign Retired   = Reset ? '0 : cnt_q;

endmodule

// File: tb/tb_control_fsm.sv
// Randomized bench for control_fsm against a table-driven reference model.
module tb_control_fsm;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic [3:0]  opcode = 4'd0;
    logic        RegDst, Branch, MemRead, MemWrite, RegWrite, MemToReg, ALUSrc, Shift;
    logic [1:0]  ALUOp;
    logic        PCWrite, Halted, IllegalOp;
    logic [15:0] Retired;
    logic        RegDst4, Branch4, MemRead4, MemWrite4, RegWrite4, MemToReg4, ALUSrc4, Shift4;
    logic [1:0]  ALUOp4;
    logic        PCWrite4, Halted4, IllegalOp4;
    logic [3:0]  Retired4;

    always #5 Clock = ~Clock;

    control_fsm #(.CNT_W(16), .HALT_OP(4'b1111)) dut (
        .Clock(Clock), .Reset(Reset), .opcode(opcode), .RegDst(RegDst), .Branch(Branch),
        .MemRead(MemRead), .MemWrite(MemWrite), .RegWrite(RegWrite), .MemToReg(MemToReg),
        .ALUSrc(ALUSrc), .Shift(Shift), .ALUOp(ALUOp), .PCWrite(PCWrite), .Halted(Halted),
        .IllegalOp(IllegalOp), .Retired(Retired)
    );

    control_fsm #(.CNT_W(4), .HALT_OP(4'b1111)) dut4 (
        .Clock(Clock), .Reset(Reset), .opcode(opcode), .RegDst(RegDst4), .Branch(Branch4),
        .MemRead(MemRead4), .MemWrite(MemWrite4), .RegWrite(RegWrite4), .MemToReg(MemToReg4),
        .ALUSrc(ALUSrc4), .Shift(Shift4), .ALUOp(ALUOp4), .PCWrite(PCWrite4), .Halted(Halted4),
        .IllegalOp(IllegalOp4), .Retired(Retired4)
    );

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Field order: RegDst Branch MemRead MemWrite RegWrite MemToReg ALUSrc Shift ALUOp PCWrite Halted IllegalOp
    function automatic logic [12:0] mk(input bit rd, input bit br, input bit mr, input bit mw,
                                       input bit rw, input bit m2r, input bit as, input bit sh,
                                       input logic [1:0] aop, input bit pcw, input bit hlt,
                                       input bit ill);
        return {rd, br, mr, mw, rw, m2r, as, sh, aop, pcw, hlt, ill};
    endfunction

    logic [12:0] exec_tbl [16];
    bit          m_halted = 1'b0;
    bit          m_access = 1'b0;
    int unsigned m_retired = 0;

    function automatic logic [12:0] model_out(input logic [3:0] op, input bit rst);
        bit ld;
        if (rst) return '0;
        if (m_halted) return mk(0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 0, 1, 0);
        if (m_access) begin
            ld = (op == 4'd5);
            return mk(0, 0, ld, !ld, ld, ld, 1, 0, 2'd0, 1, 0, 0);
        end
        return exec_tbl[op];
    endfunction

    task automatic step(input logic [3:0] op, input bit rst);
        logic [12:0] exp, obs;
        #1;
        opcode = op;
        Reset  = rst;
        @(negedge Clock);
        exp = model_out(op, rst);
        obs = {RegDst, Branch, MemRead, MemWrite, RegWrite, MemToReg, ALUSrc, Shift, ALUOp,
               PCWrite, Halted, IllegalOp};
        check_eq("ctrl", 32'(obs), 32'(exp));
        check_eq("retired", 32'(Retired), rst ? 32'd0 : 32'(m_retired % 65536));
        check_eq("retired4", 32'(Retired4), rst ? 32'd0 : 32'(m_retired % 16));
        check_eq("rd_wr_excl", 32'(MemRead & MemWrite), 32'd0);
        check_eq("branch_no_wr", 32'(Branch & RegWrite), 32'd0);
        @(posedge Clock);
        if (rst) begin
            m_halted  = 1'b0;
            m_access  = 1'b0;
            m_retired = 0;
        end else begin
            m_retired += 32'(exp[2]);
            if (m_halted) m_halted = 1'b1;
            else if (m_access) m_access = 1'b0;
            else if (op == 4'hF) m_halted = 1'b1;
            else if (op == 4'd5 || op == 4'd6) m_access = 1'b1;
        end
    endtask

    initial begin
        logic [3:0] op;
        bit rst;
        for (int i = 0; i < 16; i++) exec_tbl[i] = mk(0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 1, 0, 1);
        exec_tbl[0]  = mk(1, 0, 0, 0, 1, 0, 0, 0, 2'b10, 1, 0, 0);
        exec_tbl[1]  = mk(1, 0, 0, 0, 1, 0, 0, 1, 2'b00, 1, 0, 0);
        exec_tbl[2]  = mk(0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 1, 0, 0);
        exec_tbl[3]  = mk(0, 0, 0, 0, 1, 0, 1, 0, 2'b11, 1, 0, 0);
        exec_tbl[4]  = mk(0, 0, 0, 0, 1, 0, 1, 0, 2'b11, 1, 0, 0);
        exec_tbl[5]  = mk(0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 0, 0, 0);
        exec_tbl[6]  = mk(0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 0, 0, 0);
        exec_tbl[7]  = mk(0, 1, 0, 0, 0, 0, 0, 0, 2'b01, 1, 0, 0);
        exec_tbl[15] = '0;

        // Reset, then three R-type instructions.
        step(4'd0, 1'b1);
        step(4'd0, 1'b1);
        repeat (3) step(4'd0, 1'b0);
        #1 check_eq("retired_after_3", 32'(Retired), 32'd3);

        // LW held for two cycles retires once.
        step(4'd5, 1'b0);
        step(4'd5, 1'b0);
        #1 check_eq("retired_after_lw", 32'(Retired), 32'd4);

        // SW with reset in the MEM cycle.
        step(4'd6, 1'b0);
        step(4'd6, 1'b1);
        #1 check_eq("retired_sw_reset", 32'(Retired), 32'd0);

        // BEQ, then an illegal opcode.
        step(4'd7, 1'b0);
        step(4'hA, 1'b0);
        step(4'd0, 1'b0);

        // HALT freezes the machine until reset.
        step(4'hF, 1'b0);
        repeat (10) step(4'd0, 1'b0);
        #1 check_eq("halted_held", 32'(Halted), 32'd1);
        check_eq("retired_frozen", 32'(Retired), 32'd3);
        step(4'd0, 1'b1);
        step(4'd0, 1'b0);

        // Counter wrap on the 4-bit build.
        step(4'd0, 1'b1);
        repeat (17) step(4'd0, 1'b0);
        #1 check_eq("retired4_wrap", 32'(Retired4), 32'd1);

        // Random traffic; memory ops mostly hold their opcode through MEM.
        op = 4'd0;
        for (int i = 0; i < 600; i++) begin
            if (!(m_access && $urandom_range(0, 9) != 0)) op = 4'($urandom_range(0, 15));
            if (m_halted) rst = ($urandom_range(0, 7) == 0);
            else rst = ($urandom_range(0, 39) == 0);
            step(op, rst);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
